// File: rtl/rgb_to_cry.sv
// RGB888 -> Jaguar CRY encoder: normalise the pixel to full intensity with three
// restoring dividers, then scan the 256-entry hue ROM for the nearest entry.
module rgb_to_cry #(
  parameter bit FAST_BLACK = 1'b1
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic [7:0]  rom_addr,
  output logic        rom_en,
  input  logic [23:0] rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_cry
);

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned NUM_W   = 16;
  localparam int unsigned SAD_W   = 10;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned N_LANES = 3;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SCAN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_in_ready;
  logic              r_out_valid;
  logic [15:0]       r_out_cry;
  logic [PIX_W-1:0]  r_rom_addr;
  logic              r_rom_en;
  logic              r_cmp_vld;
  logic [PIX_W-1:0]  r_cmp_idx;
  logic [SAD_W-1:0]  r_best_sad;
  logic [PIX_W-1:0]  r_best_idx;
  logic [CNT_W-1:0]  r_div_cnt;
  logic [PIX_W-1:0]  r_y;
  logic [PIX_W-1:0]  r_rem   [N_LANES];
  logic [PIX_W-1:0]  r_numlo [N_LANES];
  logic [PIX_W-1:0]  r_q     [N_LANES];

  logic              w_accept;
  logic              w_black;
  logic              w_last_cmp;
  logic              w_better;
  logic [PIX_W-1:0]  w_y;
  logic [PIX_W-1:0]  w_pix   [N_LANES];
  logic [NUM_W-1:0]  w_num   [N_LANES];
  logic [PIX_W:0]    w_trial [N_LANES];
  logic              w_ge    [N_LANES];
  logic [PIX_W-1:0]  w_rom_c [N_LANES];
  logic [PIX_W-1:0]  w_diff  [N_LANES];
  logic [SAD_W-1:0]  w_sad;
  logic [PIX_W-1:0]  w_best_idx_nxt;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_cry   = r_out_cry;
  assign rom_addr  = r_rom_addr;
  assign rom_en    = r_rom_en;

  assign w_accept   = in_valid & r_in_ready;
  assign w_y        = (in_r >= in_g) ? ((in_r >= in_b) ? in_r : in_b)
                                     : ((in_g >= in_b) ? in_g : in_b);
  assign w_black    = FAST_BLACK && (w_y == '0);
  assign w_last_cmp = r_cmp_vld && (r_cmp_idx == {PIX_W{1'b1}});

  // Per-lane numerator x*255, divider trial subtract and SAD term against the ROM entry.
  always_comb begin
    w_pix[0]   = in_r;
    w_pix[1]   = in_g;
    w_pix[2]   = in_b;
    w_rom_c[0] = rom_data[23:16];
    w_rom_c[1] = rom_data[15:8];
    w_rom_c[2] = rom_data[7:0];
    for (int i = 0; i < N_LANES; i++) begin
      w_num[i]   = {w_pix[i], 8'h00} - NUM_W'(w_pix[i]);
      w_trial[i] = {r_rem[i], r_numlo[i][PIX_W-1]};
      w_ge[i]    = (r_y != '0) && (w_trial[i] >= {1'b0, r_y});
      w_diff[i]  = (r_q[i] >= w_rom_c[i]) ? (r_q[i] - w_rom_c[i]) : (w_rom_c[i] - r_q[i]);
    end
  end

  assign w_sad          = SAD_W'(w_diff[0]) + SAD_W'(w_diff[1]) + SAD_W'(w_diff[2]);
  assign w_better       = w_sad < r_best_sad;
  assign w_best_idx_nxt = w_better ? r_cmp_idx : r_best_idx;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_black ? S_DONE : S_DIV;
      S_DIV:  if (r_div_cnt == {CNT_W{1'b1}}) w_state_nxt = S_SCAN;
      S_SCAN: if (w_last_cmp) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; compare stage trails the ROM address by one cycle.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_cry   <= '0;
      r_rom_addr  <= '0;
      r_rom_en    <= 1'b0;
      r_cmp_vld   <= 1'b0;
      r_cmp_idx   <= '0;
      r_best_sad  <= {SAD_W{1'b1}};
      r_best_idx  <= '0;
      r_div_cnt   <= '0;
      r_y         <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        r_rem[i]   <= '0;
        r_numlo[i] <= '0;
        r_q[i]     <= '0;
      end
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_cmp_vld   <= r_rom_en;
      r_cmp_idx   <= r_rom_addr;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_y       <= w_y;
            r_div_cnt <= '0;
            for (int i = 0; i < N_LANES; i++) begin
              r_rem[i]   <= w_num[i][NUM_W-1:PIX_W];
              r_numlo[i] <= w_num[i][PIX_W-1:0];
              r_q[i]     <= '0;
            end
            if (w_black) r_out_cry <= '0;
          end
        end
        S_DIV: begin
          r_div_cnt <= r_div_cnt + CNT_W'(1);
          for (int i = 0; i < N_LANES; i++) begin
            r_rem[i]   <= w_ge[i] ? PIX_W'(w_trial[i] - {1'b0, r_y}) : w_trial[i][PIX_W-1:0];
            r_numlo[i] <= {r_numlo[i][PIX_W-2:0], 1'b0};
            r_q[i]     <= {r_q[i][PIX_W-2:0], w_ge[i]};
          end
          if (r_div_cnt == {CNT_W{1'b1}}) begin
            r_rom_addr <= '0;
            r_rom_en   <= 1'b1;
          end
        end
        S_SCAN: begin
          if (r_rom_en) begin
            if (r_rom_addr == {PIX_W{1'b1}}) r_rom_en <= 1'b0;
            else                             r_rom_addr <= r_rom_addr + PIX_W'(1);
          end
          if (r_cmp_vld && w_better) begin
            r_best_sad <= w_sad;
            r_best_idx <= r_cmp_idx;
          end
          if (w_last_cmp) r_out_cry <= {w_best_idx_nxt, r_y};
        end
        S_DONE: begin
          if (out_ready) begin
            r_best_sad <= {SAD_W{1'b1}};
            r_rom_addr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
